// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   - uart_state_t : receiver FSM states
//   - OVERSAMPLE, DATA_BITS, MID_SAMPLE : frame geometry constants
//   - calc_div()   : clocks per oversample tick from clock and baud rate
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } uart_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int MID_SAMPLE = 8;

  // Integer division truncates; callers must keep the result >= 2.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator, shared by receiver and transmitter.
//   Parameter DIV : clocks per tick (>= 2).
//   CLK50M in  : system clock
//   RST    in  : asynchronous active-high reset
//   en     in  : count enable; counter is held at 0 while low so the first
//                tick lands exactly DIV clocks after en rises
//   tick   out : one-cycle pulse every DIV clocks while enabled
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic CLK50M,
  input  logic RST,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge CLK50M or posedge RST) begin
    if (RST) begin
      count_reg <= '0;
    end else if (!en || count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign tick = en && (count_reg == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling, running on CLK50M.
//   Parameters: CLK_FREQ (Hz), BAUD (bit/s), PARITY_ODD (0 even, 1 odd).
//   CLK50M     in  : system clock
//   RST        in  : asynchronous active-high reset
//   RXD        in  : serial line, idle high, asynchronous
//   DATA       out : last correctly received byte (held until next good frame)
//   VALID      out : one-cycle pulse, DATA updated this cycle
//   FRAME_ERR  out : one-cycle pulse, stop bit sampled low
//   PARITY_ERR out : one-cycle pulse, parity mismatch (0 unless parity build)
//   BUSY       out : high while a frame is being received or the line is in break
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit after bit 7.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int PARITY_ODD = 0
) (
  input  logic       CLK50M,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FRAME_ERR,
  output logic       PARITY_ERR,
  output logic       BUSY
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);
  localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
`else
  // Parity sense has no effect in 8N1 builds; the empty block only keeps the
  // parameter referenced so overrides stay harmless.
  if (PARITY_ODD != 0) begin : g_parity_odd_ignored
  end
`endif

  // Two-flop synchronizer, reset to the idle line level.
  logic meta_reg, rxs_reg;

  always_ff @(posedge CLK50M or posedge RST) begin
    if (RST) begin
      meta_reg <= 1'b1;
      rxs_reg  <= 1'b1;
    end else begin
      meta_reg <= RXD;
      rxs_reg  <= meta_reg;
    end
  end

  uart_state_t state_reg, state_next;
  logic [3:0]  sample_reg, sample_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  data_reg, data_next;
  logic        valid_reg, valid_next;
  logic        frame_err_reg, frame_err_next;
  logic        tick;
  logic        tick_en;
`ifdef UART_RX_PARITY_EN
  logic        parity_bad_reg, parity_bad_next;
  logic        parity_err_reg, parity_err_next;
`endif

  // Counter idles at 0 so the first tick is phase-aligned to the start edge.
  assign tick_en = (state_reg != S_IDLE) && (state_reg != S_BREAK);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .CLK50M(CLK50M),
    .RST   (RST),
    .en    (tick_en),
    .tick  (tick)
  );

  always_ff @(posedge CLK50M or posedge RST) begin
    if (RST) begin
      state_reg      <= S_IDLE;
      sample_reg     <= '0;
      bit_reg        <= '0;
      shift_reg      <= '0;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_reg <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      sample_reg     <= sample_next;
      bit_reg        <= bit_next;
      shift_reg      <= shift_next;
      data_reg       <= data_next;
      valid_reg      <= valid_next;
      frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
      parity_bad_reg <= parity_bad_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    sample_next     = sample_reg;
    bit_next        = bit_reg;
    shift_next      = shift_reg;
    data_next       = data_reg;
    valid_next      = 1'b0;
    frame_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_next = parity_bad_reg;
    parity_err_next = 1'b0;
`endif

    case (state_reg)
      S_IDLE: begin
        sample_next = '0;
        if (!rxs_reg) begin
          state_next = S_START;
        end
      end

      S_START: begin
        if (tick) begin
          if (sample_reg == MID_LAST) begin
            // Mid start bit: a high line here was only a glitch.
            sample_next = '0;
            bit_next    = '0;
            state_next  = rxs_reg ? S_IDLE : S_DATA;
          end else begin
            sample_next = sample_reg + 4'd1;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          sample_next = sample_reg + 4'd1;
          if (sample_reg == BIT_LAST) begin
            // LSB arrives first, so shifting in from the top rebuilds the byte.
            shift_next = {rxs_reg, shift_reg[7:1]};
            if (bit_reg == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_next = S_PARITY;
`else
              state_next = S_STOP;
`endif
            end else begin
              bit_next = bit_reg + 3'd1;
            end
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          sample_next = sample_reg + 4'd1;
          if (sample_reg == BIT_LAST) begin
            parity_bad_next = (rxs_reg != ((^shift_reg) ^ PAR_ODD));
            state_next      = S_STOP;
          end
        end
      end
`endif

      S_STOP: begin
        if (tick) begin
          sample_next = sample_reg + 4'd1;
          if (sample_reg == BIT_LAST) begin
            if (rxs_reg) begin
              // Leaving at mid-stop lets a back-to-back start edge be seen.
              state_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (parity_bad_reg) begin
                parity_err_next = 1'b1;
              end else begin
                data_next  = shift_reg;
                valid_next = 1'b1;
              end
`else
              data_next  = shift_reg;
              valid_next = 1'b1;
`endif
            end else begin
              frame_err_next = 1'b1;
              state_next     = S_BREAK;
            end
          end
        end
      end

      S_BREAK: begin
        // A held-low line must not be mistaken for a stream of start bits.
        if (rxs_reg) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign DATA      = data_reg;
  assign VALID     = valid_reg;
  assign FRAME_ERR = frame_err_reg;
  assign BUSY      = (state_reg != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR = parity_err_reg;
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx with DIV = 4.
// An event queue predicts each frame's outcome (good byte, framing error,
// parity error) and its arrival time from frame contents; a compare process
// checks pulses and DATA against it every cycle.
module tb_uart_rx;

  localparam int BAUD       = 115200;
  localparam int DIV        = 4;
  localparam int CLK_FREQ   = 16 * BAUD * DIV;
  localparam int BIT_CLKS   = 16 * DIV;
  localparam int PARITY_ODD = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .PARITY_ODD(PARITY_ODD)
  ) u_dut (
    .CLK50M    (clk),
    .RST       (rst),
    .RXD       (rxd),
    .DATA      (data),
    .VALID     (valid),
    .FRAME_ERR (frame_err),
    .PARITY_ERR(parity_err),
    .BUSY      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef enum {EV_VALID, EV_FERR, EV_PERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] byte_v;
    int         due;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] exp_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model: outcome and arrival time follow from the frame alone.
  // Start edge seen after 2 sync flops, then 8 ticks to mid-start plus 16 per
  // following bit up to mid-stop (152 ticks for 8N1, 168 with parity).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic par_bit, input bit use_par);
    ev_t e;
    int  ticks;
    ticks = 8 + 16 * (8 + 1 + (use_par ? 1 : 0));
    e.due    = cyc + 2 + ticks * DIV;
    e.byte_v = b;
    if (!stop_bit)
      e.kind = EV_FERR;
    else if (use_par && (par_bit != ((^b) ^ (PARITY_ODD != 0))))
      e.kind = EV_PERR;
    else
      e.kind = EV_VALID;
    exp_q.push_back(e);
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (use_par) begin
      rxd = par_bit;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : compare
    ev_t      e;
    ev_kind_t got;
    if (!rst) begin
      check("pulse_exclusive", 32'(int'(valid) + int'(frame_err) + int'(parity_err) <= 1), 32'd1);
      if (valid || frame_err || parity_err) begin
        got = valid ? EV_VALID : (frame_err ? EV_FERR : EV_PERR);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_pulse: got %s required none (cycle %0d)", got.name(), cyc);
        end else begin
          e = exp_q.pop_front();
          tests++;
          if (got != e.kind) begin
            fails++;
            $display("[TB] FAIL pulse_kind: got %s required %s (cycle %0d)", got.name(), e.kind.name(), cyc);
          end
          tests++;
          if (cyc < e.due - 1 || cyc > e.due + 1) begin
            fails++;
            $display("[TB] FAIL pulse_time: got cycle %0d required %0d +/-1", cyc, e.due);
          end
          if (e.kind == EV_VALID) exp_data = e.byte_v;
          $display("[TB] event %s byte %02h at cycle %0d (due %0d)", got.name(), e.byte_v, cyc, e.due);
        end
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].due + 1) begin
        e = exp_q.pop_front();
        tests++;
        fails++;
        $display("[TB] FAIL missing_pulse: got none required %s by cycle %0d", e.kind.name(), e.due + 1);
      end
      check("data_hold", 32'(data), 32'(exp_data));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset state
    rst = 1'b1;
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(10);
    check("idle_busy", 32'(busy), 32'd0);

    // Good frame 0x55
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    idle(20);
    check("data_55", 32'(data), 32'h55);
    check("queue_55", 32'(exp_q.size()), 32'd0);
    check("busy_after_55", 32'(busy), 32'd0);
    $display("[TB] frame 0x55 done, DATA=%02h", data);

    // False start: low for 4 ticks only
    rxd = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    check("false_start_busy_hi", 32'(busy), 32'd1);
    rxd = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("false_start_busy_lo", 32'(busy), 32'd0);
    $display("[TB] false start done, BUSY=%0d", busy);

    // 0xA3 with a low stop bit, line held low three more bit times
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("break_busy", 32'(busy), 32'd1);
    check("break_data", 32'(data), 32'h55);
    idle(10);
    check("break_exit_busy", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    idle(20);
    check("data_3c", 32'(data), 32'h3C);
    $display("[TB] break then 0x3C done, DATA=%02h", data);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    idle(20);
    check("data_ff", 32'(data), 32'hFF);
    check("queue_b2b", 32'(exp_q.size()), 32'd0);
    $display("[TB] back-to-back 0x00/0xFF done, DATA=%02h", data);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the parity bit must be 1
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    idle(20);
    check("par_ok_data", 32'(data), 32'h07);
    send_frame(8'h81, 1'b1, 1'b1, 1'b1);
    idle(20);
    check("par_bad_data", 32'(data), 32'h07);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    idle(20);
    check("par_bad2_data", 32'(data), 32'h07);
    check("queue_par", 32'(exp_q.size()), 32'd0);
    $display("[TB] parity frames done, DATA=%02h", data);
`endif

    // Reset at mid bit 3 of a frame
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rxd = 1'b0; repeat (BIT_CLKS) @(negedge clk);
    rxd = 1'b1; repeat (BIT_CLKS) @(negedge clk);
    rxd = 1'b0; repeat (BIT_CLKS) @(negedge clk);
    rxd = 1'b1; repeat (BIT_CLKS / 2) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    exp_data = 8'h00;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_data", 32'(data), 32'h00);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_data", 32'(data), 32'h00);
    $display("[TB] mid-frame reset done, DATA=%02h", data);

    // One more good frame after reset
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    idle(20);
    check("data_81", 32'(data), 32'h81);
    check("queue_final", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
